cu_irq_gen2: RTL
================

Name: cu_irq_gen2

Overview:
- Second-generation Moore control unit for the 16-bit RISC processor.
- Keeps the fetch/decode/execute sequencing and control word of the current CU.
- Generalised in instruction width and register-address width.
- Adds memory wait states (mem_rdy handshake), a single maskable interrupt with saved flags, and EI/DI/IRET instructions.
- Sits between the instruction register/memory and the execution unit.

Parameters:
- IR_W, 16, instruction width. Constraint: IR_W >= 3*RA_W+7.
- RA_W, 3, register-file address width.
- OPC: the opcode is IR[IR_W-1:IR_W-7] (7 bits). Register fields are W=IR[3*RA_W-1:2*RA_W], R=IR[2*RA_W-1:RA_W], S=IR[RA_W-1:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- IR  in  IR_W  instruction register
- N, Z, C  in  1 each  ALU flags of the current cycle
- mem_rdy  in  1  memory completes the access this cycle
- irq  in  1  level interrupt request
- W_Adr, R_Adr, S_Adr  out  RA_W each  register-file addresses
- adr_sel, s_sel  out  1 each  memory address mux, write-back source mux
- pc_ld, pc_inc, ir_ld  out  1 each  PC load, PC increment, IR load
- pc_sel  out  2  PC source: 0 = PC+se(IR[7:0]), 1 = R[S], 2 = interrupt vector, 3 = saved PC
- pc_save  out  1  execution unit copies PC into its shadow register
- mw_en, rw_en  out  1 each  memory write enable, register-file write enable
- alu_op  out  4  ALU operation
- irq_ack  out  1  interrupt acknowledge
- ie  out  1  interrupt-enable flag (registered)
- status  out  8  LED state code

Behaviour:
- One clock. Reset is synchronous and active-high: on posedge clk with reset=1, state<=RESET, {N,Z,C} flag register<=0, shadow flags<=0, ie<=0.
- Outputs decode from the registered state. The only exceptions are the mem_rdy gating noted below.
- Every state not listed drives all-zero controls.
- States: RESET, FETCH, DECODE, ADD, SUB, CMP, MOV, SHL, SHR, INC, DEC, LD, STO, LDI, HALT, JE, JNE, JC, JMP, EI, DI, IRET, INTR, ILLEGAL.
- RESET: all controls 0, status=8'hFF, next FETCH.
- FETCH: ir_ld=pc_inc=mem_rdy, status=8'h80. Stays in FETCH while mem_rdy=0; moves to DECODE when mem_rdy=1.
- DECODE: status=8'hC0. Opcode map:
  - 0x70 ADD, 0x71 SUB, 0x72 CMP, 0x73 MOV, 0x74 SHL, 0x75 SHR, 0x76 INC, 0x77 DEC
  - 0x78 LD, 0x79 STO, 0x7A LDI, 0x7B HALT, 0x7C JE, 0x7D JNE, 0x7E JC, 0x7F JMP
  - 0x6C DI, 0x6D EI, 0x6F IRET
  - anything else goes to ILLEGAL.
- ALU states use single-cycle controls identical to gen-1, with alu_op:
  - ADD 0100, SUB/CMP 0101, SHL 0111, SHR 0110, INC 0010, DEC 0011, MOV 0000.
  - CMP has rw_en=0.
  - The flag register loads {N,Z,C} at the end of the state for every ALU state except MOV.
- LD: adr_sel=1, s_sel=1, rw_en=mem_rdy. Held until mem_rdy=1.
- STO: adr_sel=1, mw_en=1 for every cycle in the state. Held until mem_rdy=1.
- LDI: s_sel=1, rw_en=pc_inc=mem_rdy. Held until mem_rdy=1.
- JE/JNE/JC: pc_sel=0; pc_ld=Z / ~Z / C taken from the flag register.
- JMP: pc_sel=1, pc_ld=1, S_Adr=S.
- Flags are preserved in every state that does not load them.
- EI/DI: ie<=1 / ie<=0 at the end of the state.
- IRET: pc_ld=1, pc_sel=3, flag register<=shadow flags, ie<=1.
- INTR (one cycle): irq_ack=1, pc_save=1, pc_ld=1, pc_sel=2, shadow flags<=flag register, ie<=0, status=8'hA0, next FETCH.
- Interrupt check happens only at instruction completion, i.e. the final cycle of any execute state. If irq && ie (ie's pre-update value), next is INTR; otherwise FETCH. Because the check uses the pre-update ie, EI's own completion never takes an interrupt.
- HALT: stays in HALT until irq && ie, then goes to INTR.
- ILLEGAL: status=8'hF0; absorbing until reset.
- Execute status = {flag N, Z, C, code}. Codes:
  - ADD 00000, SUB 00001, CMP 00010, MOV 00011, SHL 00100, SHR 00101, INC 00110, DEC 00111
  - LD 01000, STO 01001, LDI 01010, HALT 01011, JE 01100, JNE 01101, JC 01110, JMP 01111
  - EI 10000, DI 10001, IRET 10010
- Wait cycles show the same status as their state.
- Reset asserted mid-wait or mid-instruction aborts it: the next cycle is RESET, and no mw_en/rw_en is asserted in that cycle.

Test Plan:
- Reset then IR=0xE0D1 (ADD R3,R2,R1), mem_rdy=1, irq=0 -> RESET, FETCH, DECODE, ADD. In ADD: W=3, R=2, S=1, rw_en=1, alu_op=0100. Then FETCH; status 8'hFF, 8'h80, 8'hC0, {NZC,00000}.
- FETCH with mem_rdy=0 for 3 cycles -> state held 3 cycles with ir_ld=pc_inc=0; asserted on the 4th cycle; STO with the same stall keeps mw_en=1 for all 4 cycles.
- EI, then irq=1 during ADD with Z=1 -> INTR follows ADD (irq_ack=pc_save=pc_ld=1, pc_sel=2, ie=0). Later IRET restores Z=1, ie=1, pc_sel=3.
- DI with irq=1 held -> no INTR across 5 instructions. HALT with ie=1: irq rising causes HALT->INTR->FETCH.
- CMP setting Z=1, then JNE -> pc_ld=0; then JE -> pc_ld=1, pc_sel=0.
- IR opcode 0x00 -> ILLEGAL, status 8'hF0 held for 10 cycles; reset during LD wait -> RESET next cycle, rw_en=0.

Source files
------------

// File: rtl/cu_irq_gen2.sv
// -----------------------------------------------------------------------------
// cu_irq_gen2 -- second-generation Moore control unit for the 16-bit RISC core.
//
// Sequences fetch / decode / execute and produces the control word for the
// execution unit. Compared with the first generation it adds memory wait
// states (mem_rdy handshake), one maskable level interrupt with a saved copy
// of the flags, and the EI / DI / IRET instructions.
//
// Parameters
//   IR_W  instruction width (IR_W >= 3*RA_W+7)
//   RA_W  register-file address width
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   IR                       instruction register: opcode in IR[IR_W-1 -: 7],
//                            register fields W / R / S in the low 3*RA_W bits
//   N, Z, C                  ALU flags produced in the current cycle
//   mem_rdy                  memory completes its access this cycle
//   irq                      level-sensitive interrupt request
//   W_Adr, R_Adr, S_Adr      register-file addresses
//   adr_sel, s_sel           memory address mux, write-back source mux
//   pc_ld, pc_inc, ir_ld     PC load, PC increment, IR load
//   pc_sel                   PC source: 0 PC+se(IR[7:0]), 1 R[S], 2 vector,
//                            3 saved PC
//   pc_save                  execution unit copies PC into its shadow register
//   mw_en, rw_en             memory write enable, register-file write enable
//   alu_op                   ALU operation
//   irq_ack                  interrupt acknowledge
//   ie                       interrupt-enable flag (registered)
//   status                   LED state code
// -----------------------------------------------------------------------------
module cu_irq_gen2 #(
    parameter int IR_W = 16,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] IR,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            mem_rdy,
    input  logic            irq,
    output logic [RA_W-1:0] W_Adr,
    output logic [RA_W-1:0] R_Adr,
    output logic [RA_W-1:0] S_Adr,
    output logic            adr_sel,
    output logic            s_sel,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            ir_ld,
    output logic [1:0]      pc_sel,
    output logic            pc_save,
    output logic            mw_en,
    output logic            rw_en,
    output logic [3:0]      alu_op,
    output logic            irq_ack,
    output logic            ie,
    output logic [7:0]      status
);

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE,
        S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
        S_LD, S_STO, S_LDI, S_HALT,
        S_JE, S_JNE, S_JC, S_JMP,
        S_EI, S_DI, S_IRET,
        S_INTR, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OPC_ADD  = 7'h70;
    localparam logic [6:0] OPC_SUB  = 7'h71;
    localparam logic [6:0] OPC_CMP  = 7'h72;
    localparam logic [6:0] OPC_MOV  = 7'h73;
    localparam logic [6:0] OPC_SHL  = 7'h74;
    localparam logic [6:0] OPC_SHR  = 7'h75;
    localparam logic [6:0] OPC_INC  = 7'h76;
    localparam logic [6:0] OPC_DEC  = 7'h77;
    localparam logic [6:0] OPC_LD   = 7'h78;
    localparam logic [6:0] OPC_STO  = 7'h79;
    localparam logic [6:0] OPC_LDI  = 7'h7A;
    localparam logic [6:0] OPC_HALT = 7'h7B;
    localparam logic [6:0] OPC_JE   = 7'h7C;
    localparam logic [6:0] OPC_JNE  = 7'h7D;
    localparam logic [6:0] OPC_JC   = 7'h7E;
    localparam logic [6:0] OPC_JMP  = 7'h7F;
    localparam logic [6:0] OPC_DI   = 7'h6C;
    localparam logic [6:0] OPC_EI   = 7'h6D;
    localparam logic [6:0] OPC_IRET = 7'h6F;

    state_t          state, next_state;
    logic [2:0]      flags;        // {N, Z, C} as of the last flag-setting op
    logic [2:0]      shadow_flags; // flags saved on interrupt entry

    // Internal register-update strobes decoded alongside the control word.
    logic            flag_ld, flag_restore, shadow_ld, ie_set, ie_clr;

    logic [6:0]      opc;
    logic [RA_W-1:0] fld_w, fld_r, fld_s;
    logic            irq_take;
    state_t          after_instr;

    assign opc   = IR[IR_W-1 -: 7];
    assign fld_w = IR[3*RA_W-1 -: RA_W];
    assign fld_r = IR[2*RA_W-1 -: RA_W];
    assign fld_s = IR[RA_W-1:0];

    // Interrupts are sampled against the current (pre-update) ie, so an EI
    // completing in this cycle cannot itself be interrupted.
    assign irq_take    = irq && ie;
    assign after_instr = irq_take ? S_INTR : S_FETCH;

    // -------------------------------------------------------------------------
    // State and architectural flag registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RESET;
            flags        <= 3'b000;
            shadow_flags <= 3'b000;
            ie           <= 1'b0;
        end else begin
            state <= next_state;
            if (flag_ld)
                flags <= {N, Z, C};
            else if (flag_restore)
                flags <= shadow_flags;
            if (shadow_ld)
                shadow_flags <= flags;
            if (ie_set)
                ie <= 1'b1;
            else if (ie_clr)
                ie <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        next_state = S_RESET;
        unique case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opc)
                    OPC_ADD:  next_state = S_ADD;
                    OPC_SUB:  next_state = S_SUB;
                    OPC_CMP:  next_state = S_CMP;
                    OPC_MOV:  next_state = S_MOV;
                    OPC_SHL:  next_state = S_SHL;
                    OPC_SHR:  next_state = S_SHR;
                    OPC_INC:  next_state = S_INC;
                    OPC_DEC:  next_state = S_DEC;
                    OPC_LD:   next_state = S_LD;
                    OPC_STO:  next_state = S_STO;
                    OPC_LDI:  next_state = S_LDI;
                    OPC_HALT: next_state = S_HALT;
                    OPC_JE:   next_state = S_JE;
                    OPC_JNE:  next_state = S_JNE;
                    OPC_JC:   next_state = S_JC;
                    OPC_JMP:  next_state = S_JMP;
                    OPC_DI:   next_state = S_DI;
                    OPC_EI:   next_state = S_EI;
                    OPC_IRET: next_state = S_IRET;
                    default:  next_state = S_ILLEGAL;
                endcase
            end
            S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
            S_JE, S_JNE, S_JC, S_JMP, S_EI, S_DI, S_IRET:
                next_state = after_instr;
            // Memory states complete only on the cycle the memory is ready.
            S_LD, S_STO, S_LDI:
                next_state = mem_rdy ? after_instr : state;
            S_HALT:    next_state = irq_take ? S_INTR : S_HALT;
            S_INTR:    next_state = S_FETCH;
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_RESET;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (Moore, except mem_rdy gating in FETCH / LD / LDI)
    // -------------------------------------------------------------------------
    always_comb begin
        W_Adr        = '0;
        R_Adr        = '0;
        S_Adr        = '0;
        adr_sel      = 1'b0;
        s_sel        = 1'b0;
        pc_ld        = 1'b0;
        pc_inc       = 1'b0;
        ir_ld        = 1'b0;
        pc_sel       = 2'd0;
        pc_save      = 1'b0;
        mw_en        = 1'b0;
        rw_en        = 1'b0;
        alu_op       = 4'b0000;
        irq_ack      = 1'b0;
        status       = 8'h00;
        flag_ld      = 1'b0;
        flag_restore = 1'b0;
        shadow_ld    = 1'b0;
        ie_set       = 1'b0;
        ie_clr       = 1'b0;

        unique case (state)
            S_RESET:  status = 8'hFF;
            S_FETCH: begin
                ir_ld  = mem_rdy;
                pc_inc = mem_rdy;
                status = 8'h80;
            end
            S_DECODE: status = 8'hC0;

            S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC: begin
                W_Adr   = fld_w;
                R_Adr   = fld_r;
                S_Adr   = fld_s;
                rw_en   = (state != S_CMP);
                flag_ld = (state != S_MOV);
                case (state)
                    S_ADD:   begin alu_op = 4'b0100; status = {flags, 5'b00000}; end
                    S_SUB:   begin alu_op = 4'b0101; status = {flags, 5'b00001}; end
                    S_CMP:   begin alu_op = 4'b0101; status = {flags, 5'b00010}; end
                    S_MOV:   begin alu_op = 4'b0000; status = {flags, 5'b00011}; end
                    S_SHL:   begin alu_op = 4'b0111; status = {flags, 5'b00100}; end
                    S_SHR:   begin alu_op = 4'b0110; status = {flags, 5'b00101}; end
                    S_INC:   begin alu_op = 4'b0010; status = {flags, 5'b00110}; end
                    default: begin alu_op = 4'b0011; status = {flags, 5'b00111}; end
                endcase
            end

            S_LD: begin
                W_Adr   = fld_w;
                R_Adr   = fld_r;
                S_Adr   = fld_s;
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                rw_en   = mem_rdy;
                status  = {flags, 5'b01000};
            end
            S_STO: begin
                // Write enable held through the whole stall; the memory
                // decides when the write has landed.
                W_Adr   = fld_w;
                R_Adr   = fld_r;
                S_Adr   = fld_s;
                adr_sel = 1'b1;
                mw_en   = 1'b1;
                status  = {flags, 5'b01001};
            end
            S_LDI: begin
                W_Adr   = fld_w;
                R_Adr   = fld_r;
                S_Adr   = fld_s;
                s_sel   = 1'b1;
                rw_en   = mem_rdy;
                pc_inc  = mem_rdy;
                status  = {flags, 5'b01010};
            end
            S_HALT: status = {flags, 5'b01011};

            S_JE: begin
                pc_ld  = flags[1];
                status = {flags, 5'b01100};
            end
            S_JNE: begin
                pc_ld  = ~flags[1];
                status = {flags, 5'b01101};
            end
            S_JC: begin
                pc_ld  = flags[0];
                status = {flags, 5'b01110};
            end
            S_JMP: begin
                S_Adr  = fld_s;
                pc_ld  = 1'b1;
                pc_sel = 2'd1;
                status = {flags, 5'b01111};
            end

            S_EI: begin
                ie_set = 1'b1;
                status = {flags, 5'b10000};
            end
            S_DI: begin
                ie_clr = 1'b1;
                status = {flags, 5'b10001};
            end
            S_IRET: begin
                pc_ld        = 1'b1;
                pc_sel       = 2'd3;
                flag_restore = 1'b1;
                ie_set       = 1'b1;
                status       = {flags, 5'b10010};
            end

            S_INTR: begin
                irq_ack   = 1'b1;
                pc_save   = 1'b1;
                pc_ld     = 1'b1;
                pc_sel    = 2'd2;
                shadow_ld = 1'b1;
                ie_clr    = 1'b1;
                status    = 8'hA0;
            end
            S_ILLEGAL: status = 8'hF0;
            default: ;
        endcase
    end

endmodule
